// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: store buffer toward the data cache, access checks, registered load path.
// Optional build macro LSU_LOAD_BYPASS_EN lets hazard-free loads overtake buffered stores.
module load_store_unit #(
    parameter int SB_DEPTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  wb_sel,
    input  logic [ADDR_WIDTH-1:0] alu_result,
    input  logic [31:0]           store_src,
    input  logic [2:0]            func3,
    output logic                  busywait,
    output logic [31:0]           wb_data,
    output logic                  mem_exception,
    output logic                  dc_read,
    output logic                  dc_write,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic [31:0]           dc_wdata,
    output logic [3:0]            dc_byteen,
    input  logic [31:0]           dc_rdata,
    input  logic                  dc_busywait
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  load_done_q, load_done_d;
    logic [31:0]           result_q, result_d;

    logic [ADDR_WIDTH-1:0] sb_addr_q [SB_DEPTH];
    logic [31:0]           sb_data_q [SB_DEPTH];
    logic [3:0]            sb_be_q   [SB_DEPTH];

    logic [ADDR_WIDTH-1:0] ld_addr_q;
    logic [1:0]            ld_off_q;
    logic [2:0]            ld_f3_q;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            byte_off;
    logic                  ld_f3_ok, st_f3_ok, aligned;
    logic                  ld_ok, st_ok;
    logic                  sb_full, hazard, push, pop, ld_start;

    function automatic logic [31:0] store_wdata(input logic [31:0] src, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [31:0] lane;
        case (f3[1:0])
            2'b00:   lane = {24'h0, src[7:0]};
            2'b01:   lane = {16'h0, src[15:0]};
            default: lane = src;
        endcase
        return lane << {off, 3'b000};
    endfunction

    function automatic logic [3:0] store_byteen(input logic [1:0] off, input logic [2:0] f3);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be << off;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h0, sh[7:0]};
            3'b101:  res = {16'h0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Access decode: size/sign legality and natural alignment
    always_comb begin
        word_addr = {alu_result[ADDR_WIDTH-1:2], 2'b00};
        byte_off  = alu_result[1:0];
        ld_f3_ok  = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3_ok  = func3 inside {3'b000, 3'b001, 3'b010};
        case (func3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~byte_off[0];
            2'b10:   aligned = (byte_off == 2'b00);
            default: aligned = 1'b0;
        endcase
        ld_ok         = mem_read & ld_f3_ok & aligned;
        st_ok         = mem_write & st_f3_ok & aligned;
        mem_exception = (mem_read & ~(ld_f3_ok & aligned)) | (mem_write & ~(st_f3_ok & aligned));
    end

`ifdef LSU_LOAD_BYPASS_EN
    logic [PTR_W-1:0] hz_idx;

    always_comb begin
        hazard = 1'b0;
        hz_idx = rd_ptr_q;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hz_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (sb_addr_q[hz_idx] == word_addr)) begin
                hazard = 1'b1;
            end
        end
    end
`else
    assign hazard = (count_q != '0);
`endif

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early
    assign sb_full  = (count_q == CNT_W'(SB_DEPTH));
    assign push     = st_ok & ~sb_full;
    assign busywait = (st_ok & sb_full) | (ld_ok & ~load_done_q);
    assign wb_data  = wb_sel ? result_q : 32'(alu_result);

    always_comb begin
        state_d     = state_q;
        ld_start    = 1'b0;
        pop         = 1'b0;
        load_done_d = 1'b0;
        result_d    = result_q;
        dc_read     = 1'b0;
        dc_write    = 1'b0;
        dc_addr     = '0;
        dc_wdata    = '0;
        dc_byteen   = '0;
        case (state_q)
            IDLE: begin
                if (ld_ok && !hazard && !load_done_q) begin
                    state_d  = LOAD;
                    ld_start = 1'b1;
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            LOAD: begin
                dc_read = 1'b1;
                dc_addr = ld_addr_q;
                if (!dc_busywait) begin
                    result_d    = load_extract(dc_rdata, ld_off_q, ld_f3_q);
                    load_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                dc_write  = 1'b1;
                dc_addr   = sb_addr_q[rd_ptr_q];
                dc_wdata  = sb_data_q[rd_ptr_q];
                dc_byteen = sb_be_q[rd_ptr_q];
                if (!dc_busywait) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            load_done_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            load_done_q <= load_done_d;
            result_q    <= result_d;
        end
    end

    // Payload storage carries no reset; validity comes from the pointers and count
    always_ff @(posedge clock) begin
        if (push) begin
            sb_addr_q[wr_ptr_q] <= word_addr;
            sb_data_q[wr_ptr_q] <= store_wdata(store_src, byte_off, func3);
            sb_be_q[wr_ptr_q]   <= store_byteen(byte_off, func3);
        end
        if (ld_start) begin
            ld_addr_q <= word_addr;
            ld_off_q  <= byte_off;
            ld_f3_q   <= func3;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: cache writes and load results checked against queued expectations.
module tb_load_store_unit;
    localparam int SBD = 4;

    logic        clock;
    logic        reset;
    logic        mem_read, mem_write, wb_sel;
    logic [31:0] alu_result, store_src;
    logic [2:0]  func3;
    logic        busywait, mem_exception, dc_read, dc_write, dc_busywait;
    logic [31:0] wb_data, dc_addr, dc_wdata, dc_rdata;
    logic [3:0]  dc_byteen;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t         exp_wq[$];
    logic [31:0] exp_lq[$];
    logic [31:0] mem [logic [31:0]];

    int n_checks = 0, n_pass = 0, n_wr = 0, n_unexp = 0, cyc = 0;
    int first_rd = -1, first_wr = -1, req_cnt = 0, dc_wait = 0;
    bit dc_hold = 0;

    load_store_unit #(.SB_DEPTH(SBD), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .wb_sel(wb_sel), .alu_result(alu_result), .store_src(store_src), .func3(func3),
        .busywait(busywait), .wb_data(wb_data), .mem_exception(mem_exception),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_byteen(dc_byteen), .dc_rdata(dc_rdata), .dc_busywait(dc_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Cache model: drives wait states and read data, commits and scoreboards every write
    always @(negedge clock) begin
        wr_t e;
        logic [31:0] w;
        if (dc_read || dc_write) begin
            if (dc_hold) dc_busywait = 1'b1;
            else if (req_cnt < dc_wait) begin
                dc_busywait = 1'b1;
                req_cnt++;
            end else begin
                dc_busywait = 1'b0;
                req_cnt = 0;
            end
        end else begin
            dc_busywait = 1'b0;
            req_cnt = 0;
        end
        if (dc_read) begin
            if (first_rd < 0) first_rd = cyc;
            dc_rdata = mem.exists(dc_addr) ? mem[dc_addr] : 32'h0;
        end
        if (dc_write && first_wr < 0) first_wr = cyc;
        if (dc_write && !dc_busywait) begin
            n_wr++;
            if (exp_wq.size() == 0) n_unexp++;
            else begin
                e = exp_wq.pop_front();
                check("wr_addr", dc_addr, e.addr);
                check("wr_data", dc_wdata, e.data);
                check("wr_be", {28'h0, dc_byteen}, {28'h0, e.be});
            end
            w = mem.exists(dc_addr) ? mem[dc_addr] : 32'h0;
            for (int b = 0; b < 4; b++) if (dc_byteen[b]) w[b*8 +: 8] = dc_wdata[b*8 +: 8];
            mem[dc_addr] = w;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] src, input logic [31:0] exp_data,
                            input logic [3:0] exp_be, output int stalls);
        wr_t e;
        e.addr = {addr[31:2], 2'b00};
        e.data = exp_data;
        e.be   = exp_be;
        exp_wq.push_back(e);
        mem_write = 1'b1; func3 = f3; alu_result = addr; store_src = src;
        stalls = 0;
        @(negedge clock);
        while (busywait && stalls < 64) begin
            stalls++;
            @(negedge clock);
        end
        check({tag, "_accept"}, {31'h0, busywait}, 32'h0);
        tick();
        mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp, output int stalls);
        logic [31:0] e;
        exp_lq.push_back(exp);
        mem_read = 1'b1; wb_sel = 1'b1; func3 = f3; alu_result = addr;
        stalls = 0;
        @(negedge clock);
        while (busywait && stalls < 64) begin
            stalls++;
            @(negedge clock);
        end
        check({tag, "_done"}, {31'h0, busywait}, 32'h0);
        e = exp_lq.pop_front();
        check({tag, "_data"}, wb_data, e);
        tick();
        mem_read = 1'b0; wb_sel = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_wq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(exp_wq.size()), 32'h0);
        repeat (2) tick();
    endtask

    initial begin
        int st, base, exp_stall;
        int st5;
        logic exp_bypass;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; wb_sel = 1'b1;
        alu_result = 32'h1234ABCD; store_src = 32'h0; func3 = 3'b000;
        dc_rdata = 32'h0; dc_busywait = 1'b0;
        mem[32'h400] = 32'h12345678;
`ifdef LSU_LOAD_BYPASS_EN
        exp_bypass = 1'b1;
`else
        exp_bypass = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_busywait", {31'h0, busywait}, 32'h0);
        check("rst_dc_read", {31'h0, dc_read}, 32'h0);
        check("rst_dc_write", {31'h0, dc_write}, 32'h0);
        check("rst_dc_addr", dc_addr, 32'h0);
        check("rst_dc_wdata", dc_wdata, 32'h0);
        check("rst_dc_byteen", {28'h0, dc_byteen}, 32'h0);
        check("rst_result", wb_data, 32'h0);
        wb_sel = 1'b0;
        #1;
        check("rst_alu_bypass", wb_data, 32'h1234ABCD);
        tick();
        reset = 1'b0;

        // SW then LW to the same word: the load waits for the drain
        base = n_wr;
        do_store("t1_sw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, st);
        check("t1_sw_stall", 32'(st), 32'd0);
        do_load("t1_lw", 3'b010, 32'h100, 32'hDEADBEEF, st);
        check("t1_lw_stall", 32'(st), 32'd4);
        check("t1_writes", 32'(n_wr - base), 32'd1);

        // Byte and halfword lanes with sign/zero extension
        do_store("t2_sb", 3'b000, 32'h203, 32'h00000080, 32'h80000000, 4'b1000, st);
        wait_drain("t2_sb");
        do_load("t2_lb", 3'b000, 32'h203, 32'hFFFFFF80, st);
        check("t2_lb_stall", 32'(st), 32'd2);
        do_load("t2_lbu", 3'b100, 32'h203, 32'h00000080, st);
        check("t2_lbu_stall", 32'(st), 32'd2);
        do_load("t2_lh", 3'b001, 32'h202, 32'hFFFF8000, st);
        do_load("t2_lhu", 3'b101, 32'h202, 32'h00008000, st);
        do_store("t2_sh", 3'b001, 32'h022, 32'h1234BEEF, 32'hBEEF0000, 4'b1100, st);
        wait_drain("t2_sh");
        do_load("t2_lw20", 3'b010, 32'h020, 32'hBEEF0000, st);
        do_load("t2_lhu22", 3'b101, 32'h022, 32'h0000BEEF, st);

        // Each cache wait cycle adds one stall
        dc_wait = 2;
        do_load("t2_lw_wait", 3'b010, 32'h400, 32'h12345678, st);
        check("t2_wait_stall", 32'(st), 32'd4);
        dc_wait = 0;

        // Fill the buffer against a stalled cache; only the extra store stalls
        dc_hold = 1'b1;
        for (int i = 0; i < SBD; i++) begin
            do_store("t3_fill", 3'b010, 32'h500 + 32'(4 * i), 32'hA0000000 + 32'(i),
                     32'hA0000000 + 32'(i), 4'b1111, st);
            check("t3_fill_stall", 32'(st), 32'd0);
        end
        fork
            do_store("t3_over", 3'b010, 32'h500 + 32'(4 * SBD), 32'hA0000000 + 32'(SBD),
                     32'hA0000000 + 32'(SBD), 4'b1111, st5);
            begin
                repeat (3) @(posedge clock);
                #1;
                dc_hold = 1'b0;
            end
        join
        check("t3_full_stall", {31'h0, st5 != 0}, 32'h1);
        wait_drain("t3");

        // Illegal accesses raise the exception without stalling or touching the cache
        mem_read = 1'b1; func3 = 3'b001; alu_result = 32'h101;
        @(negedge clock);
        check("t4_lh_exc", {31'h0, mem_exception}, 32'h1);
        check("t4_lh_bw", {31'h0, busywait}, 32'h0);
        tick();
        @(negedge clock);
        check("t4_lh_no_read", {31'h0, dc_read}, 32'h0);
        func3 = 3'b011; alu_result = 32'h100;
        #1;
        check("t4_f3_exc", {31'h0, mem_exception}, 32'h1);
        tick();
        mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b010; alu_result = 32'h102;
        @(negedge clock);
        check("t4_sw_exc", {31'h0, mem_exception}, 32'h1);
        check("t4_sw_bw", {31'h0, busywait}, 32'h0);
        tick();
        func3 = 3'b100; alu_result = 32'h100;
        @(negedge clock);
        check("t4_s100_exc", {31'h0, mem_exception}, 32'h1);
        tick();
        mem_write = 1'b0;
        tick();
        @(negedge clock);
        check("t4_no_write", {31'h0, dc_write}, 32'h0);
        check("t4_no_read2", {31'h0, dc_read}, 32'h0);
        tick();

        // Hazard-free load versus a buffered store: ordering depends on the bypass build
        first_rd = -1; first_wr = -1;
        do_store("t5_sw", 3'b010, 32'h300, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, st);
        do_load("t5_lw", 3'b010, 32'h400, 32'h12345678, st);
        exp_stall = exp_bypass ? 2 : 4;
        check("t5_lw_stall", 32'(st), 32'(exp_stall));
        wait_drain("t5");
        check("t5_order", {31'h0, (first_rd >= 0) && (first_wr >= 0) && (first_rd < first_wr)},
              {31'h0, exp_bypass});

        // Reset in the middle of a drain discards buffered stores
        dc_hold = 1'b1;
        for (int i = 0; i < 3; i++)
            do_store("t6_fill", 3'b010, 32'h600 + 32'(4 * i), 32'hB0000000 + 32'(i),
                     32'hB0000000 + 32'(i), 4'b1111, st);
        @(negedge clock);
        check("t6_drain_active", {31'h0, dc_write}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_wq.delete();
        @(negedge clock);
        check("t6_rst_write", {31'h0, dc_write}, 32'h0);
        check("t6_rst_read", {31'h0, dc_read}, 32'h0);
        check("t6_rst_addr", dc_addr, 32'h0);
        check("t6_rst_byteen", {28'h0, dc_byteen}, 32'h0);
        dc_hold = 1'b0;
        base = n_wr;
        repeat (8) tick();
        check("t6_no_writes", 32'(n_wr - base), 32'd0);
        dc_hold = 1'b1;
        for (int i = 0; i < SBD; i++) begin
            do_store("t6_refill", 3'b010, 32'h700 + 32'(4 * i), 32'hC0000000 + 32'(i),
                     32'hC0000000 + 32'(i), 4'b1111, st);
            check("t6_refill_stall", 32'(st), 32'd0);
        end
        dc_hold = 1'b0;
        wait_drain("t6");

        check("unexp_writes", 32'(n_unexp), 32'd0);
        check("load_queue_empty", 32'(exp_lq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
